// File: rtl/slc3_control.sv
// SLC-3 control unit: Moore FSM sequencing fetch, decode and execute.
// Every control output is decoded from the current state alone.
module slc3_control (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       cont,
  input  logic [3:0] opcode,
  input  logic       ir11,
  input  logic       branch_enable,
  input  logic       mem_resp,
  output logic       mem_read,
  output logic       mem_write,
  output logic       LD_PC,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       load_regfile,
  output logic       load_cc,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] aluop,
  output logic       ADDR1MUX,
  output logic       MARMUX,
  output logic       DRMUX,
  output logic       alumux_sel,
  output logic       r7_sel,
  output logic       halted,
  output logic       paused
);

  typedef enum logic [4:0] {
    S_HALTED, S_F1, S_F2, S_F3, S_DECODE,
    S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKE,
    S_JMP, S_JSR_LINK, S_JSR_JUMP,
    S_LDR1, S_LDR2, S_LDR3,
    S_STR1, S_STR2, S_STR3, S_PAUSE
  } state_t;

  state_t state, state_nx;
  logic   cont_q;
  logic   jsr_imm_q;

  // IR[11] is captured so JSR_JUMP outputs stay a pure state function
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_HALTED;
      cont_q    <= 1'b0;
      jsr_imm_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cont_q <= cont;
      if (state == S_JSR_LINK)
        jsr_imm_q <= ir11;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_HALTED:   if (run) state_nx = S_F1;
      S_F1:       state_nx = S_F2;
      S_F2:       if (mem_resp) state_nx = S_F3;
      S_F3:       state_nx = S_DECODE;
      S_DECODE: begin
        case (opcode)
          4'b0001: state_nx = S_ADD;
          4'b0101: state_nx = S_AND;
          4'b1001: state_nx = S_NOT;
          4'b0000: state_nx = S_BR;
          4'b1100: state_nx = S_JMP;
          4'b0100: state_nx = S_JSR_LINK;
          4'b0110: state_nx = S_LDR1;
          4'b0111: state_nx = S_STR1;
          4'b1101: state_nx = S_PAUSE;
          default: state_nx = S_F1;
        endcase
      end
      S_ADD, S_AND, S_NOT: state_nx = S_F1;
      S_BR:
        state_nx = branch_enable ? S_BR_TAKE : S_F1;
      S_BR_TAKE, S_JMP: state_nx = S_F1;
      S_JSR_LINK: state_nx = S_JSR_JUMP;
      S_JSR_JUMP: state_nx = S_F1;
      S_LDR1:     state_nx = S_LDR2;
      S_LDR2:     if (mem_resp) state_nx = S_LDR3;
      S_LDR3:     state_nx = S_F1;
      S_STR1:     state_nx = S_STR2;
      S_STR2:     state_nx = S_STR3;
      S_STR3:     if (mem_resp) state_nx = S_F1;
      S_PAUSE:
        if (cont && !cont_q) state_nx = S_F1;
      default:    state_nx = S_HALTED;
    endcase
  end

  always_comb begin
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    LD_PC        = 1'b0;
    LD_MAR       = 1'b0;
    LD_MDR       = 1'b0;
    LD_IR        = 1'b0;
    load_regfile = 1'b0;
    load_cc      = 1'b0;
    GatePC       = 1'b0;
    GateMDR      = 1'b0;
    GateALU      = 1'b0;
    GateMARMUX   = 1'b0;
    PCMUX        = 2'b00;
    ADDR2MUX     = 2'b00;
    aluop        = 2'b00;
    ADDR1MUX     = 1'b0;
    MARMUX       = 1'b0;
    DRMUX        = 1'b0;
    alumux_sel   = 1'b0;
    r7_sel       = 1'b0;
    halted       = 1'b0;
    paused       = 1'b0;
    unique case (state)
      S_HALTED: halted = 1'b1;
      S_F1: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
      end
      S_F2, S_LDR2: begin
        mem_read = 1'b1;
        LD_MDR   = 1'b1;
      end
      S_F3: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S_ADD, S_AND, S_NOT: begin
        aluop = (state == S_ADD) ? 2'b00 :
                (state == S_AND) ? 2'b01 : 2'b10;
        GateALU      = 1'b1;
        load_regfile = 1'b1;
        load_cc      = 1'b1;
      end
      S_BR_TAKE: begin
        ADDR2MUX = 2'b01;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
      end
      S_JMP: begin
        aluop   = 2'b11;
        GateALU = 1'b1;
        PCMUX   = 2'b01;
        LD_PC   = 1'b1;
      end
      S_JSR_LINK: begin
        GatePC       = 1'b1;
        r7_sel       = 1'b1;
        load_regfile = 1'b1;
      end
      S_JSR_JUMP: begin
        LD_PC = 1'b1;
        if (jsr_imm_q) begin
          PCMUX = 2'b10;
        end else begin
          aluop   = 2'b11;
          GateALU = 1'b1;
          PCMUX   = 2'b01;
        end
      end
      S_LDR1, S_STR1: begin
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'b10;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      S_LDR3: begin
        GateMDR      = 1'b1;
        load_regfile = 1'b1;
        load_cc      = 1'b1;
      end
      S_STR2: begin
        aluop   = 2'b11;
        GateALU = 1'b1;
        DRMUX   = 1'b1;
        LD_MDR  = 1'b1;
      end
      S_STR3:  mem_write = 1'b1;
      S_PAUSE: paused = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_slc3_control.sv
// Randomized instruction-level bench for slc3_control.
// Expected control words come from a per-instruction step model.
module tb_slc3_control;

  logic       clk = 1'b0;
  logic       reset, run, cont, ir11;
  logic       branch_enable, mem_resp;
  logic [3:0] opcode;
  logic       mem_read, mem_write, LD_PC, LD_MAR;
  logic       LD_MDR, LD_IR, load_regfile, load_cc;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, aluop;
  logic       ADDR1MUX, MARMUX, DRMUX, alumux_sel;
  logic       r7_sel, halted, paused;

  typedef struct packed {
    logic       rd, wr, ld_pc, ld_mar, ld_mdr, ld_ir;
    logic       ld_reg, ld_cc, g_pc, g_mdr, g_alu, g_mm;
    logic [1:0] pcmux, a2mux, aluop;
    logic       a1mux, marmux, drmux, alumux, r7;
    logic       halted, paused;
  } cw_t;

  cw_t  obs;
  int   n_vec = 0;
  int   n_err = 0;
  logic cont_prev = 1'b0;
  bit   hold_cont = 1'b0;

  assign obs = {mem_read, mem_write, LD_PC, LD_MAR,
                LD_MDR, LD_IR, load_regfile, load_cc,
                GatePC, GateMDR, GateALU, GateMARMUX,
                PCMUX, ADDR2MUX, aluop, ADDR1MUX,
                MARMUX, DRMUX, alumux_sel, r7_sel,
                halted, paused};

  slc3_control dut (
    .clk(clk), .reset(reset), .run(run),
    .cont(cont), .opcode(opcode), .ir11(ir11),
    .branch_enable(branch_enable),
    .mem_resp(mem_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .LD_PC(LD_PC), .LD_MAR(LD_MAR),
    .LD_MDR(LD_MDR), .LD_IR(LD_IR),
    .load_regfile(load_regfile),
    .load_cc(load_cc), .GatePC(GatePC),
    .GateMDR(GateMDR), .GateALU(GateALU),
    .GateMARMUX(GateMARMUX), .PCMUX(PCMUX),
    .ADDR2MUX(ADDR2MUX), .aluop(aluop),
    .ADDR1MUX(ADDR1MUX), .MARMUX(MARMUX),
    .DRMUX(DRMUX), .alumux_sel(alumux_sel),
    .r7_sel(r7_sel), .halted(halted),
    .paused(paused)
  );

  always #5 clk = ~clk;

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic cw_t w_halt();
    cw_t e = '0; e.halted = 1'b1; return e;
  endfunction
  function automatic cw_t w_f1();
    cw_t e = '0;
    e.g_pc = 1'b1; e.ld_mar = 1'b1; e.ld_pc = 1'b1;
    return e;
  endfunction
  function automatic cw_t w_rd();
    cw_t e = '0; e.rd = 1'b1; e.ld_mdr = 1'b1;
    return e;
  endfunction
  function automatic cw_t w_f3();
    cw_t e = '0; e.g_mdr = 1'b1; e.ld_ir = 1'b1;
    return e;
  endfunction
  function automatic cw_t w_alu(logic [1:0] op);
    cw_t e = '0;
    e.aluop = op; e.g_alu = 1'b1;
    e.ld_reg = 1'b1; e.ld_cc = 1'b1;
    return e;
  endfunction
  function automatic cw_t w_brt();
    cw_t e = '0;
    e.a2mux = 2'b01; e.pcmux = 2'b10; e.ld_pc = 1'b1;
    return e;
  endfunction
  function automatic cw_t w_jmp();
    cw_t e = '0;
    e.aluop = 2'b11; e.g_alu = 1'b1;
    e.pcmux = 2'b01; e.ld_pc = 1'b1;
    return e;
  endfunction
  function automatic cw_t w_link();
    cw_t e = '0;
    e.g_pc = 1'b1; e.r7 = 1'b1; e.ld_reg = 1'b1;
    return e;
  endfunction
  function automatic cw_t w_jsr(logic i11);
    cw_t e = '0;
    if (i11) begin
      e.pcmux = 2'b10; e.ld_pc = 1'b1;
    end else e = w_jmp();
    return e;
  endfunction
  function automatic cw_t w_ea();
    cw_t e = '0;
    e.a1mux = 1'b1; e.a2mux = 2'b10;
    e.g_mm = 1'b1; e.ld_mar = 1'b1;
    return e;
  endfunction
  function automatic cw_t w_ldr3();
    cw_t e = '0;
    e.g_mdr = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1;
    return e;
  endfunction
  function automatic cw_t w_str2();
    cw_t e = '0;
    e.aluop = 2'b11; e.g_alu = 1'b1;
    e.drmux = 1'b1; e.ld_mdr = 1'b1;
    return e;
  endfunction
  function automatic cw_t w_str3();
    cw_t e = '0; e.wr = 1'b1; return e;
  endfunction
  function automatic cw_t w_pause();
    cw_t e = '0; e.paused = 1'b1; return e;
  endfunction

  // one clock: check at negedge, then randomize free inputs
  task automatic cyc(cw_t e, string tag);
    @(negedge clk);
    check(tag, 32'(obs), 32'(e));
    check({tag, "/gate"}, 32'($countones(
      {GatePC, GateMDR, GateALU, GateMARMUX}) <= 1), 1);
    check({tag, "/rw"}, 32'(mem_read & mem_write), 0);
    @(posedge clk);
    cont_prev = cont;
    #1;
    mem_resp = 1'($urandom);
    run      = 1'($urandom);
    cont     = hold_cont ? 1'b1 : 1'($urandom);
  endtask

  task automatic mwait(cw_t e, string tag, int lat);
    int n = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
    for (int i = 0; i < n; i++) begin
      mem_resp = 1'b0;
      cyc(e, tag);
    end
    mem_resp = 1'b1;
    cyc(e, tag);
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; cont = 1'b0;
    mem_resp = 1'b0;
    #1;
    check("reset", 32'(obs), 32'(w_halt()));
    @(posedge clk); #1;
    check("reset_hold", 32'(obs), 32'(w_halt()));
    @(negedge clk);
    reset = 1'b0; cont_prev = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      run = 1'b0;
      cyc(w_halt(), "idle");
    end
  endtask

  task automatic start();
    run = 1'b1;
    cyc(w_halt(), "go");
  endtask

  task automatic run_instr(logic [3:0] opc, logic i11,
                           logic be, int lat,
                           bit abort, bit dir);
    logic leave;
    logic pat [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    opcode = opc; ir11 = i11; branch_enable = be;
    hold_cont = dir;
    cyc(w_f1(), "F1");
    mwait(w_rd(), "F2", lat);
    cyc(w_f3(), "F3");
    cyc('0, "DECODE");
    hold_cont = 1'b0;
    case (opc)
      4'b0001: cyc(w_alu(2'b00), "ADD");
      4'b0101: cyc(w_alu(2'b01), "AND");
      4'b1001: cyc(w_alu(2'b10), "NOT");
      4'b0000: begin
        cyc('0, "BR");
        if (be) cyc(w_brt(), "BR_TAKE");
      end
      4'b1100: cyc(w_jmp(), "JMP");
      4'b0100: begin
        cyc(w_link(), "JSR_LINK");
        cyc(w_jsr(i11), "JSR_JUMP");
      end
      4'b0110: begin
        cyc(w_ea(), "LDR1");
        mwait(w_rd(), "LDR2", lat);
        cyc(w_ldr3(), "LDR3");
      end
      4'b0111: begin
        cyc(w_ea(), "STR1");
        cyc(w_str2(), "STR2");
        if (abort) begin
          mem_resp = 1'b0;
          cyc(w_str3(), "STR3");
          mem_resp = 1'b0;
          #2;
          check("str3_wait", 32'(mem_write), 1);
          reset = 1'b1;
          #1;
          check("str3_rst", 32'(obs), 32'(w_halt()));
        end else begin
          mwait(w_str3(), "STR3", lat);
        end
      end
      4'b1101: begin
        for (int k = 0; k < 16; k++) begin
          if (dir && k < 4) cont = pat[k];
          else if (k >= 6) cont = !cont_prev;
          else cont = 1'($urandom);
          leave = cont && !cont_prev;
          cyc(w_pause(), "PAUSE");
          if (leave) break;
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; cont = 1'b0;
    opcode = '0; ir11 = 1'b0;
    branch_enable = 1'b0; mem_resp = 1'b0;
    #2;
    do_reset();
    start();
    run_instr(4'b0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_instr(4'b0000, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    run_instr(4'b0000, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    run_instr(4'b0110, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    run_instr(4'b1101, 1'b0, 1'b0, -1, 1'b0, 1'b1);
    run_instr(4'b0100, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    run_instr(4'b0100, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    run_instr(4'b0111, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    run_instr(4'b1111, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    for (int i = 0; i < 120; i++)
      run_instr(4'($urandom_range(0, 15)),
                1'($urandom), 1'($urandom),
                -1, 1'b0, 1'b0);
    run_instr(4'b0111, 1'b0, 1'b0, -1, 1'b1, 1'b0);
    do_reset();
    start();
    for (int i = 0; i < 20; i++)
      run_instr(4'($urandom_range(0, 15)),
                1'($urandom), 1'($urandom),
                -1, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
